// File: rtl/product_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : product_accumulator
// Purpose  : Sums LEN consecutive products from the shift-add multiplier into
//            a saturating guarded accumulator. Each finished sum is presented
//            on a valid/ready output. One product that arrives while the
//            output is stalled is held in a single-entry pending slot, because
//            the multiplier cannot be back-pressured.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1    clock, rising edge
//   rst        in   1    asynchronous active-high reset
//   done_in    in   1    multiplier done flag (level; one product per rise)
//   p_in       in   K    multiplier product, valid while done_in=1
//   clr        in   1    synchronous clear of the current sum
//   acc_out    out  AW   finished sum (AW = K+G)
//   acc_valid  out  1    acc_out/ovf valid
//   acc_ready  in   1    consumer accepts acc_out
//   ovf        out  1    sum saturated, qualified by acc_valid
//   lost       out  1    sticky: a product was dropped
//   count      out  8    products accumulated in the current sum
// ============================================================================
module product_accumulator #(
  parameter int K   = 16,
  parameter int G   = 4,
  parameter int LEN = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            done_in,
  input  logic [K-1:0]    p_in,
  input  logic            clr,
  output logic [K+G-1:0]  acc_out,
  output logic            acc_valid,
  input  logic            acc_ready,
  output logic            ovf,
  output logic            lost,
  output logic [7:0]      count
);

  localparam int            AW      = K + G;
  localparam logic [7:0]    LEN_C   = 8'(LEN);
  localparam logic [AW-1:0] ACC_MAX = '1;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    OUT   = 1'b1
  } state_t;

  state_t          state;
  logic [AW-1:0]   acc;
  logic [K-1:0]    pend;
  logic            pend_full;
  logic            done_d;

  logic            ev;
  logic [AW-1:0]   p_ext;
  logic [AW:0]     sum_wide;
  logic [AW-1:0]   sum_sat;
  logic [7:0]      count_inc;
  logic            stash;
  logic            drop;

  // One product event per rising edge of the level-type done flag.
  assign ev        = done_in & ~done_d;
  assign p_ext     = AW'(p_in);

  // One extra bit catches the carry out of the accumulator for saturation.
  assign sum_wide  = {1'b0, acc} + {1'b0, p_ext};
  assign sum_sat   = sum_wide[AW] ? ACC_MAX : sum_wide[AW-1:0];
  assign count_inc = count + 8'd1;

  // While a finished sum is waiting, an event either fills the pending slot
  // or, if the slot is already taken, is dropped.
  assign stash     = ev & ~pend_full;
  assign drop      = ev &  pend_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      acc_out   <= '0;
      acc_valid <= 1'b0;
      ovf       <= 1'b0;
      lost      <= 1'b0;
      count     <= 8'd0;
      pend      <= '0;
      pend_full <= 1'b0;
      done_d    <= 1'b0;
    end else begin
      // Edge history keeps tracking even through clr, so a done level that
      // spans the clear is not counted again afterwards.
      done_d <= done_in;

      if (clr) begin
        state     <= ACCUM;
        acc       <= '0;
        acc_valid <= 1'b0;
        ovf       <= 1'b0;
        lost      <= 1'b0;
        count     <= 8'd0;
        pend_full <= 1'b0;
      end else begin
        case (state)
          ACCUM: begin
            if (count == LEN_C) begin
              // A sum seeded on transfer is already complete (LEN=1):
              // present it now; any event meanwhile behaves as in OUT.
              state     <= OUT;
              acc_valid <= 1'b1;
              acc_out   <= acc;
              if (stash) begin
                pend      <= p_in;
                pend_full <= 1'b1;
              end
              if (drop) begin
                lost <= 1'b1;
              end
            end else if (ev) begin
              acc   <= sum_sat;
              count <= count_inc;
              if (sum_wide[AW]) begin
                ovf <= 1'b1;
              end
              if (count_inc == LEN_C) begin
                state     <= OUT;
                acc_valid <= 1'b1;
                acc_out   <= sum_sat;
              end
            end
          end

          OUT: begin
            if (acc_ready) begin
              state     <= ACCUM;
              acc_valid <= 1'b0;
              ovf       <= 1'b0;
              if (pend_full) begin
                // The oldest waiting product seeds the new sum; a product
                // arriving on this same edge takes over the pending slot.
                acc   <= AW'(pend);
                count <= 8'd1;
                if (ev) begin
                  pend <= p_in;
                end else begin
                  pend_full <= 1'b0;
                end
              end else if (ev) begin
                acc   <= p_ext;
                count <= 8'd1;
              end else begin
                acc   <= '0;
                count <= 8'd0;
              end
            end else begin
              if (stash) begin
                pend      <= p_in;
                pend_full <= 1'b1;
              end
              if (drop) begin
                lost <= 1'b1;
              end
            end
          end

          default: begin
            state <= ACCUM;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_product_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_product_accumulator
// Purpose  : Self-checking bench for product_accumulator. Four instances with
//            different G/LEN share one stimulus stream; each is compared every
//            cycle against a behavioural model of its sums, pending slot and
//            sticky flags. Directed scenarios are followed by random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        done_in = 1'b0;
  logic [15:0] p_in = 16'd0;
  logic        clr = 1'b0;
  logic        acc_ready = 1'b0;

  logic [19:0] acc_out_a, acc_out_c, acc_out_d;
  logic [16:0] acc_out_b;
  logic        valid_a, valid_b, valid_c, valid_d;
  logic        ovf_a, ovf_b, ovf_c, ovf_d;
  logic        lost_a, lost_b, lost_c, lost_d;
  logic [7:0]  count_a, count_b, count_c, count_d;

  always #5 clk = ~clk;

  product_accumulator #(.K(16), .G(4), .LEN(4)) dut_a (
    .clk(clk), .rst(rst), .done_in(done_in), .p_in(p_in), .clr(clr),
    .acc_out(acc_out_a), .acc_valid(valid_a), .acc_ready(acc_ready),
    .ovf(ovf_a), .lost(lost_a), .count(count_a));

  product_accumulator #(.K(16), .G(1), .LEN(4)) dut_b (
    .clk(clk), .rst(rst), .done_in(done_in), .p_in(p_in), .clr(clr),
    .acc_out(acc_out_b), .acc_valid(valid_b), .acc_ready(acc_ready),
    .ovf(ovf_b), .lost(lost_b), .count(count_b));

  product_accumulator #(.K(16), .G(4), .LEN(2)) dut_c (
    .clk(clk), .rst(rst), .done_in(done_in), .p_in(p_in), .clr(clr),
    .acc_out(acc_out_c), .acc_valid(valid_c), .acc_ready(acc_ready),
    .ovf(ovf_c), .lost(lost_c), .count(count_c));

  product_accumulator #(.K(16), .G(4), .LEN(1)) dut_d (
    .clk(clk), .rst(rst), .done_in(done_in), .p_in(p_in), .clr(clr),
    .acc_out(acc_out_d), .acc_valid(valid_d), .acc_ready(acc_ready),
    .ovf(ovf_d), .lost(lost_d), .count(count_d));

  // Observed outputs gathered per instance.
  logic [31:0] obs_acc   [4];
  logic        obs_valid [4];
  logic        obs_ovf   [4];
  logic        obs_lost  [4];
  logic [7:0]  obs_cnt   [4];

  assign obs_acc[0] = 32'(acc_out_a);
  assign obs_acc[1] = 32'(acc_out_b);
  assign obs_acc[2] = 32'(acc_out_c);
  assign obs_acc[3] = 32'(acc_out_d);
  assign obs_valid[0] = valid_a;
  assign obs_valid[1] = valid_b;
  assign obs_valid[2] = valid_c;
  assign obs_valid[3] = valid_d;
  assign obs_ovf[0] = ovf_a;
  assign obs_ovf[1] = ovf_b;
  assign obs_ovf[2] = ovf_c;
  assign obs_ovf[3] = ovf_d;
  assign obs_lost[0] = lost_a;
  assign obs_lost[1] = lost_b;
  assign obs_lost[2] = lost_c;
  assign obs_lost[3] = lost_d;
  assign obs_cnt[0] = count_a;
  assign obs_cnt[1] = count_b;
  assign obs_cnt[2] = count_c;
  assign obs_cnt[3] = count_d;

  // Instance configuration seen by the model.
  int c_len [4] = '{4, 4, 2, 1};
  int c_aw  [4] = '{20, 17, 20, 20};

  // Model state: running sum and its product count, the sum on offer, a
  // one-deep pending slot, sticky flags and the previous done level.
  longint m_sum  [4];
  int     m_n    [4];
  bit     m_ovf  [4];
  bit     m_lost [4];
  bit     m_have [4];
  longint m_out  [4];
  bit     m_pf   [4];
  longint m_pend [4];
  bit     m_prev [4];

  int checks = 0;
  int errors = 0;
  logic rdy = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_sum[i] = 0; m_n[i] = 0; m_ovf[i] = 0; m_lost[i] = 0;
      m_have[i] = 0; m_out[i] = 0; m_pf[i] = 0; m_pend[i] = 0; m_prev[i] = 0;
    end
  endfunction

  // A product seen while a sum is on offer waits in the slot or is lost.
  function automatic void model_park(input int i, input longint p);
    if (!m_pf[i]) begin
      m_pf[i] = 1; m_pend[i] = p;
    end else begin
      m_lost[i] = 1;
    end
  endfunction

  function automatic void model_step(input int i, input bit d, input longint p,
                                     input bit c, input bit r);
    bit     ev;
    longint maxv;
    longint q[$];
    maxv = (longint'(1) << c_aw[i]) - 1;
    ev = d && !m_prev[i];
    m_prev[i] = d;
    if (c) begin
      m_sum[i] = 0; m_n[i] = 0; m_ovf[i] = 0; m_lost[i] = 0;
      m_have[i] = 0; m_pf[i] = 0;
      return;
    end
    if (m_have[i]) begin
      if (r) begin
        // Sum taken: waiting products, oldest first, start the next sum.
        m_have[i] = 0; m_ovf[i] = 0;
        if (m_pf[i]) q.push_back(m_pend[i]);
        if (ev) q.push_back(p);
        m_pf[i] = 0; m_sum[i] = 0; m_n[i] = 0;
        if (q.size() > 0) begin m_sum[i] = q.pop_front(); m_n[i] = 1; end
        if (q.size() > 0) begin m_pend[i] = q.pop_front(); m_pf[i] = 1; end
      end else if (ev) begin
        model_park(i, p);
      end
    end else if (m_n[i] == c_len[i]) begin
      m_have[i] = 1; m_out[i] = m_sum[i];
      if (ev) model_park(i, p);
    end else if (ev) begin
      m_sum[i] = m_sum[i] + p;
      if (m_sum[i] > maxv) begin m_sum[i] = maxv; m_ovf[i] = 1; end
      m_n[i]++;
      if (m_n[i] == c_len[i]) begin m_have[i] = 1; m_out[i] = m_sum[i]; end
    end
  endfunction

  task automatic check_all();
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("valid%0d", i), 32'(obs_valid[i]), 32'(m_have[i]));
      check_eq($sformatf("acc%0d", i),   obs_acc[i],        32'(m_out[i]));
      check_eq($sformatf("ovf%0d", i),   32'(obs_ovf[i]),   32'(m_ovf[i]));
      check_eq($sformatf("lost%0d", i),  32'(obs_lost[i]),  32'(m_lost[i]));
      check_eq($sformatf("count%0d", i), 32'(obs_cnt[i]),   32'(m_n[i]));
    end
  endtask

  // One clock: drive inputs, advance model at the edge, compare just after.
  task automatic cyc(input logic d, input logic [15:0] p, input logic c, input logic r);
    done_in = d; p_in = p; clr = c; acc_ready = r;
    @(posedge clk);
    for (int i = 0; i < 4; i++) model_step(i, d, longint'(p), c, r);
    #1;
    check_all();
  endtask

  task automatic pulse(input logic [15:0] p);
    cyc(1'b1, p, 1'b0, rdy);
    cyc(1'b0, p, 1'b0, rdy);
  endtask

  // Called one time unit after an edge; reset is high only between edges.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic d;
    do_reset();

    // Basic sum of four products.
    rdy = 1'b1;
    pulse(16'h0010); pulse(16'h0020); pulse(16'h0030);
    cyc(1'b1, 16'h0040, 1'b0, 1'b1);
    check_eq("t1_valid", 32'(valid_a), 32'h1);
    check_eq("t1_sum", 32'(acc_out_a), 32'h000A0);
    check_eq("t1_ovf", 32'(ovf_a), 32'h0);
    cyc(1'b0, 16'h0040, 1'b0, 1'b1);
    check_eq("t1_drop", 32'(valid_a), 32'h0);
    check_eq("t1_count", 32'(count_a), 32'h0);

    // A long done level counts as a single product.
    do_reset();
    for (int k = 0; k < 10; k++) cyc(1'b1, 16'h0005, 1'b0, 1'b1);
    cyc(1'b0, 16'h0005, 1'b0, 1'b1);
    check_eq("t2_level", 32'(count_a), 32'h1);
    pulse(16'h0005); pulse(16'h0005);
    cyc(1'b1, 16'h0005, 1'b0, 1'b1);
    check_eq("t2_sum", 32'(acc_out_a), 32'h00014);
    cyc(1'b0, 16'h0005, 1'b0, 1'b1);

    // Saturation on the one-guard-bit instance, then a clean sum.
    do_reset();
    pulse(16'hFFFF); pulse(16'hFFFF); pulse(16'hFFFF);
    cyc(1'b1, 16'hFFFF, 1'b0, 1'b1);
    check_eq("t3_sat", 32'(acc_out_b), 32'h1FFFF);
    check_eq("t3_ovf", 32'(ovf_b), 32'h1);
    cyc(1'b0, 16'hFFFF, 1'b0, 1'b1);
    pulse(16'h0001); pulse(16'h0002); pulse(16'h0003);
    cyc(1'b1, 16'h0004, 1'b0, 1'b1);
    check_eq("t3_next", 32'(acc_out_b), 32'h0000A);
    check_eq("t3_novf", 32'(ovf_b), 32'h0);
    cyc(1'b0, 16'h0004, 1'b0, 1'b1);

    // Stalled output with one pending product and later drops (LEN=2).
    do_reset();
    rdy = 1'b0;
    pulse(16'h0003);
    cyc(1'b1, 16'h0004, 1'b0, 1'b0);
    check_eq("t4_sum", 32'(acc_out_c), 32'h00007);
    cyc(1'b0, 16'h0004, 1'b0, 1'b0);
    pulse(16'h0100); pulse(16'h0200); pulse(16'h0300);
    check_eq("t4_hold", 32'(acc_out_c), 32'h00007);
    check_eq("t4_lost", 32'(lost_c), 32'h1);
    cyc(1'b0, 16'h0000, 1'b0, 1'b1);
    check_eq("t4_seed", 32'(count_c), 32'h1);
    cyc(1'b1, 16'h0400, 1'b0, 1'b0);
    check_eq("t4_next", 32'(acc_out_c), 32'h00500);
    cyc(1'b0, 16'h0400, 1'b0, 1'b0);

    // Transfer and event on the same edge with the slot empty.
    do_reset();
    pulse(16'h0001);
    cyc(1'b1, 16'h0002, 1'b0, 1'b0);
    cyc(1'b0, 16'h0002, 1'b0, 1'b0);
    cyc(1'b1, 16'h0009, 1'b0, 1'b1);
    check_eq("t5_count", 32'(count_c), 32'h1);
    check_eq("t5_valid", 32'(valid_c), 32'h0);
    check_eq("t5_lost", 32'(lost_c), 32'h0);
    cyc(1'b0, 16'h0009, 1'b0, 1'b0);
    cyc(1'b1, 16'h0001, 1'b0, 1'b0);
    check_eq("t5_sum", 32'(acc_out_c), 32'h0000A);
    cyc(1'b0, 16'h0001, 1'b0, 1'b1);

    // clr with a simultaneous event, then asynchronous reset during OUT.
    do_reset();
    rdy = 1'b1;
    pulse(16'h0001); pulse(16'h0002);
    check_eq("t6_pre", 32'(count_a), 32'h2);
    cyc(1'b1, 16'h0007, 1'b1, 1'b1);
    check_eq("t6_clr_cnt", 32'(count_a), 32'h0);
    check_eq("t6_clr_lost", 32'(lost_a), 32'h0);
    cyc(1'b0, 16'h0007, 1'b0, 1'b1);
    pulse(16'h0001); pulse(16'h0001); pulse(16'h0001);
    cyc(1'b1, 16'h0001, 1'b0, 1'b1);
    check_eq("t6_after_clr", 32'(acc_out_a), 32'h00004);
    rdy = 1'b0;
    cyc(1'b0, 16'h0001, 1'b0, 1'b1);
    pulse(16'h0011); pulse(16'h0011); pulse(16'h0011);
    cyc(1'b1, 16'h0011, 1'b0, 1'b0);
    check_eq("t6_out", 32'(valid_a), 32'h1);
    rst = 1'b1;
    #1;
    check_eq("t6_rst_valid", 32'(valid_a), 32'h0);
    check_eq("t6_rst_acc", 32'(acc_out_a), 32'h0);
    check_eq("t6_rst_count", 32'(count_a), 32'h0);
    model_reset();
    check_all();
    #1;
    rst = 1'b0;

    // Random traffic across all four configurations.
    d = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      logic [15:0] p;
      if ($urandom_range(0, 1) == 0) d = ~d;
      p = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        cyc(d, p, ($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
